seq_player_ctrl: RTL and testbench

Controller that sequences the LED pattern path. It selects the active pattern sequence from the push-buttons and copies that sequence's frames from the pattern ROM into the frame RAM. It then steps the RAM read address on every throttle tick so playback follows the throttle rate. It replaces the hand-wired ROM address and RAM write/read strobes in the top level.

---
 rtl/kros_pkg.sv | 22 ++
 rtl/pb_edge.sv | 24 ++
 rtl/seq_player_ctrl.sv | 157 +++++++++++++++
 tb/tb_seq_player_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kros_pkg.sv
// Shared types and default constants for the LED sequence player.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kros_pkg;

  // Controller phases: copy issue, pipeline drain, playback.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  localparam int SEQ_LEN_D = 16;  // frames per sequence
  localparam int NUM_SEQ_D = 8;   // sequences held in the pattern ROM
  localparam int ROM_LAT_D = 2;   // registered address + registered output
  localparam int ROM_AW_D  = 10;
  localparam int RAM_AW_D  = 7;
  localparam int ROM_DW    = 10;
  localparam int RAM_DW    = 32;
  localparam int SEQ_W     = 6;   // width of the seq_num output

endpackage

// File: rtl/pb_edge.sv
// Rising-edge detector for a debounced push-button level.
// Latency: combinational pulse in the cycle the level first reads high; history is registered.
// Backpressure: none; the edge is a single-cycle pulse, dropped if the consumer is not listening.
// Ports: i_clk clock, i_rst sync active-high reset, i_pb button level, o_rise one-cycle edge pulse.
module pb_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pb,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_pb;
    end
  end

  assign o_rise = i_pb & ~r_prev;

endmodule

// File: rtl/seq_player_ctrl.sv
// Sequence player: copies the selected ROM sequence into frame RAM, then steps playback on throttle ticks.
// Latency: copy takes SEQ_LEN+ROM_LAT cycles from entering LOAD; tick/button effects visible next cycle.
// Backpressure: none; ticks and button edges arriving during a copy are discarded, not queued.
// Ports: CLK_50/reset; step_tick, pb_seq_up/dn inputs; rom_addr/rom_q ROM port;
//        ram_wraddress/ram_data/ram_wren RAM write port; ram_rdaddress playback address;
//        seq_num, loading, frame_wrap status.
module seq_player_ctrl
  import kros_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_D,
  parameter int NUM_SEQ = NUM_SEQ_D,
  parameter int ROM_AW  = ROM_AW_D,
  parameter int RAM_AW  = RAM_AW_D,
  parameter int ROM_LAT = ROM_LAT_D
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              step_tick,
  input  logic              pb_seq_up,
  input  logic              pb_seq_dn,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_q,
  output logic [RAM_AW-1:0] ram_wraddress,
  output logic [RAM_DW-1:0] ram_data,
  output logic              ram_wren,
  output logic [RAM_AW-1:0] ram_rdaddress,
  output logic [SEQ_W-1:0]  seq_num,
  output logic              loading,
  output logic              frame_wrap
);

  state_t              r_state;
  logic [RAM_AW-1:0]   r_issue_cnt;
  logic [RAM_AW-1:0]   r_wr_cnt;
  logic [ROM_LAT-1:0]  r_vld;
  logic [ROM_AW-1:0]   r_rom_addr;
  logic [RAM_AW-1:0]   r_rdaddr;
  logic [SEQ_W-1:0]    r_seq;
  logic                r_loading;
  logic                r_frame_wrap;

  logic                w_up_rise;
  logic                w_dn_rise;
  logic                w_up;
  logic                w_dn;
  logic [SEQ_W-1:0]    w_seq_inc;
  logic [SEQ_W-1:0]    w_seq_dec;
  logic [SEQ_W-1:0]    w_next_seq;
  logic [ROM_AW-1:0]   w_next_base;
  logic                w_wr;
  logic                w_last_wr;

  pb_edge u_up_edge (
    .i_clk  (CLK_50),
    .i_rst  (reset),
    .i_pb   (pb_seq_up),
    .o_rise (w_up_rise)
  );

  pb_edge u_dn_edge (
    .i_clk  (CLK_50),
    .i_rst  (reset),
    .i_pb   (pb_seq_dn),
    .o_rise (w_dn_rise)
  );

  // Simultaneous up and down edges cancel each other out.
  assign w_up = w_up_rise & ~w_dn_rise;
  assign w_dn = w_dn_rise & ~w_up_rise;

  assign w_seq_inc   = (r_seq == SEQ_W'(NUM_SEQ - 1)) ? '0 : r_seq + 1'b1;
  assign w_seq_dec   = (r_seq == '0) ? SEQ_W'(NUM_SEQ - 1) : r_seq - 1'b1;
  assign w_next_seq  = w_up ? w_seq_inc : w_seq_dec;
  assign w_next_base = ROM_AW'(w_next_seq) * ROM_AW'(SEQ_LEN);

  // A tag leaving the end of the valid pipe marks rom_q as the data for the next RAM slot.
  assign w_wr      = r_vld[ROM_LAT-1];
  assign w_last_wr = w_wr && (r_wr_cnt == RAM_AW'(SEQ_LEN - 1));

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      r_state      <= ST_LOAD;
      r_issue_cnt  <= '0;
      r_wr_cnt     <= '0;
      r_vld        <= '0;
      r_rom_addr   <= '0;
      r_rdaddr     <= '0;
      r_seq        <= '0;
      r_loading    <= 1'b1;
      r_frame_wrap <= 1'b0;
    end else begin
      r_frame_wrap <= 1'b0;

      r_vld[0] <= (r_state == ST_LOAD);
      for (int k = 1; k < ROM_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
      end

      if (w_wr) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end

      case (r_state)
        ST_LOAD: begin
          if (r_issue_cnt == RAM_AW'(SEQ_LEN - 1)) begin
            r_state <= ST_DRAIN;
          end else begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
            r_rom_addr  <= r_rom_addr + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (w_last_wr) begin
            r_state   <= ST_PLAY;
            r_loading <= 1'b0;
            r_wr_cnt  <= '0;
          end
        end

        ST_PLAY: begin
          // A button edge takes priority; a tick in the same cycle is dropped.
          if (w_up || w_dn) begin
            r_seq       <= w_next_seq;
            r_rdaddr    <= '0;
            r_rom_addr  <= w_next_base;
            r_issue_cnt <= '0;
            r_wr_cnt    <= '0;
            r_loading   <= 1'b1;
            r_state     <= ST_LOAD;
          end else if (step_tick) begin
            if (r_rdaddr == RAM_AW'(SEQ_LEN - 1)) begin
              r_rdaddr     <= '0;
              r_frame_wrap <= 1'b1;
            end else begin
              r_rdaddr <= r_rdaddr + 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign rom_addr      = r_rom_addr;
  assign ram_wraddress = r_wr_cnt;
  assign ram_data      = {{(RAM_DW - ROM_DW){1'b0}}, rom_q};
  assign ram_wren      = w_wr;
  assign ram_rdaddress = r_rdaddr;
  assign seq_num       = r_seq;
  assign loading       = r_loading;
  assign frame_wrap    = r_frame_wrap;

endmodule

// File: tb/tb_seq_player_ctrl.sv
// Directed bench for seq_player_ctrl with a 2-cycle ROM model holding word k = k.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_player_ctrl;

  logic        CLK_50;
  logic        reset;
  logic        step_tick;
  logic        pb_seq_up;
  logic        pb_seq_dn;
  logic [9:0]  rom_addr;
  logic [9:0]  rom_q;
  logic [6:0]  ram_wraddress;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [6:0]  ram_rdaddress;
  logic [5:0]  seq_num;
  logic        loading;
  logic        frame_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  rom_a1;
  logic [6:0]  wa_q[$];
  logic [31:0] wd_q[$];

  seq_player_ctrl dut (
    .CLK_50        (CLK_50),
    .reset         (reset),
    .step_tick     (step_tick),
    .pb_seq_up     (pb_seq_up),
    .pb_seq_dn     (pb_seq_dn),
    .rom_addr      (rom_addr),
    .rom_q         (rom_q),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .ram_rdaddress (ram_rdaddress),
    .seq_num       (seq_num),
    .loading       (loading),
    .frame_wrap    (frame_wrap)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  // Pattern ROM: registered address then registered output, word k holds k.
  always @(posedge CLK_50) begin
    rom_a1 <= rom_addr;
    rom_q  <= rom_a1;
  end

  // RAM write recorder.
  always @(negedge CLK_50) begin
    if (ram_wren) begin
      wa_q.push_back(ram_wraddress);
      wd_q.push_back(ram_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
  endtask

  // Pulse the buttons for one sampled cycle; returns at the first cycle after the edge is sampled.
  task automatic press(input logic up, input logic dn);
    step();
    pb_seq_up = up;
    pb_seq_dn = dn;
    step();
    pb_seq_up = 1'b0;
    pb_seq_dn = 1'b0;
  endtask

  // Called in the first cycle of a copy; counts cycles with loading high (bounded).
  task automatic wait_load(output int n, output logic [9:0] a0, output logic [5:0] s0,
                           output logic [6:0] rd0);
    n = 0;
    a0 = '0; s0 = '0; rd0 = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK_50);
      if (c == 0) begin
        a0 = rom_addr; s0 = seq_num; rd0 = ram_rdaddress;
      end
      if (!loading) return;
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step_tick = 1'b0; pb_seq_up = 1'b0; pb_seq_dn = 1'b0;
    repeat (3) step();
    @(negedge CLK_50);
    n_tests++; if (seq_num !== 6'd0) begin n_fail++; $display("FAIL reset_seq_num: got %0d expected 0", seq_num); end
    n_tests++; if (ram_rdaddress !== 7'd0) begin n_fail++; $display("FAIL reset_rdaddress: got %0d expected 0", ram_rdaddress); end
    n_tests++; if (rom_addr !== 10'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    n_tests++; if (ram_wraddress !== 7'd0) begin n_fail++; $display("FAIL reset_wraddress: got %0d expected 0", ram_wraddress); end
    n_tests++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", ram_wren); end
    n_tests++; if (frame_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_frame_wrap: got %b expected 0", frame_wrap); end
    n_tests++; if (loading !== 1'b1) begin n_fail++; $display("FAIL reset_loading: got %b expected 1", loading); end
  endtask

  task automatic test_initial_load();
    int n; int errs; logic [9:0] a0; logic [5:0] s0; logic [6:0] rd0;
    step();
    clear_q();
    reset = 1'b0;
    wait_load(n, a0, s0, rd0);
    n_tests++; if (n !== 18) begin n_fail++; $display("FAIL init_load_cycles: got %0d expected 18", n); end
    n_tests++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL init_play_wren: got %b expected 0", ram_wren); end
    n_tests++; if (wd_q.size() !== 16) begin n_fail++; $display("FAIL init_write_count: got %0d expected 16", wd_q.size()); end
    errs = 0;
    foreach (wd_q[k]) if (wa_q[k] !== 7'(k) || wd_q[k] !== 32'(k)) errs++;
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL init_write_data: got %0d bad writes expected 0", errs); end
  endtask

  task automatic test_play_ticks();
    logic [6:0] exp_rd;
    for (int t = 1; t <= 17; t++) begin
      exp_rd = (t <= 15) ? 7'(t) : 7'(t - 16);
      step();
      step_tick = 1'b1;
      step();
      step_tick = 1'b0;
      @(negedge CLK_50);
      n_tests++; if (ram_rdaddress !== exp_rd) begin n_fail++; $display("FAIL tick_rdaddress t=%0d: got %0d expected %0d", t, ram_rdaddress, exp_rd); end
      n_tests++; if (frame_wrap !== (t == 16)) begin n_fail++; $display("FAIL tick_frame_wrap t=%0d: got %b expected %b", t, frame_wrap, (t == 16)); end
      step();
      @(negedge CLK_50);
      n_tests++; if (ram_rdaddress !== exp_rd || frame_wrap !== 1'b0) begin
        n_fail++; $display("FAIL tick_hold t=%0d: got rd=%0d fw=%b expected rd=%0d fw=0", t, ram_rdaddress, frame_wrap, exp_rd);
      end
    end
  endtask

  task automatic test_seq_up();
    int n; int errs; logic [9:0] a0; logic [5:0] s0; logic [6:0] rd0;
    clear_q();
    press(1'b1, 1'b0);
    wait_load(n, a0, s0, rd0);
    n_tests++; if (s0 !== 6'd1) begin n_fail++; $display("FAIL up_seq_num: got %0d expected 1", s0); end
    n_tests++; if (rd0 !== 7'd0) begin n_fail++; $display("FAIL up_rdaddress: got %0d expected 0", rd0); end
    n_tests++; if (a0 !== 10'd16) begin n_fail++; $display("FAIL up_first_rom_addr: got %0d expected 16", a0); end
    n_tests++; if (n !== 18) begin n_fail++; $display("FAIL up_load_cycles: got %0d expected 18", n); end
    n_tests++; if (wd_q.size() !== 16) begin n_fail++; $display("FAIL up_write_count: got %0d expected 16", wd_q.size()); end
    errs = 0;
    foreach (wd_q[k]) if (wa_q[k] !== 7'(k) || wd_q[k] !== 32'(16 + k)) errs++;
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL up_write_data: got %0d bad writes expected 0", errs); end
  endtask

  task automatic test_seq_dn_wrap();
    int n; int errs; logic [9:0] a0; logic [5:0] s0; logic [6:0] rd0;
    press(1'b0, 1'b1);
    wait_load(n, a0, s0, rd0);
    n_tests++; if (s0 !== 6'd0 || a0 !== 10'd0) begin n_fail++; $display("FAIL dn_to_zero: got seq=%0d addr=%0d expected seq=0 addr=0", s0, a0); end
    clear_q();
    press(1'b0, 1'b1);
    wait_load(n, a0, s0, rd0);
    n_tests++; if (s0 !== 6'd7) begin n_fail++; $display("FAIL dn_wrap_seq: got %0d expected 7", s0); end
    n_tests++; if (a0 !== 10'd112) begin n_fail++; $display("FAIL dn_first_rom_addr: got %0d expected 112", a0); end
    n_tests++; if (wd_q.size() !== 16) begin n_fail++; $display("FAIL dn_write_count: got %0d expected 16", wd_q.size()); end
    errs = 0;
    foreach (wd_q[k]) if (wa_q[k] !== 7'(k) || wd_q[k] !== 32'(112 + k)) errs++;
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL dn_write_data: got %0d bad writes expected 0", errs); end
  endtask

  task automatic test_both_buttons();
    int rose;
    rose = 0;
    step();
    clear_q();
    pb_seq_up = 1'b1;
    pb_seq_dn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge CLK_50);
      if (loading) rose++;
    end
    pb_seq_up = 1'b0;
    pb_seq_dn = 1'b0;
    step();
    @(negedge CLK_50);
    n_tests++; if (seq_num !== 6'd7) begin n_fail++; $display("FAIL both_seq_num: got %0d expected 7", seq_num); end
    n_tests++; if (rose !== 0) begin n_fail++; $display("FAIL both_loading: got %0d loading cycles expected 0", rose); end
    n_tests++; if (wd_q.size() !== 0) begin n_fail++; $display("FAIL both_writes: got %0d expected 0", wd_q.size()); end
  endtask

  task automatic test_hold_button();
    int loads; logic prev;
    loads = 0;
    step();
    clear_q();
    prev = loading;
    pb_seq_up = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      step();
      @(negedge CLK_50);
      if (loading && !prev) loads++;
      prev = loading;
    end
    pb_seq_up = 1'b0;
    repeat (3) step();
    @(negedge CLK_50);
    n_tests++; if (loads !== 1) begin n_fail++; $display("FAIL hold_load_count: got %0d expected 1", loads); end
    n_tests++; if (seq_num !== 6'd0) begin n_fail++; $display("FAIL hold_seq_num: got %0d expected 0", seq_num); end
    n_tests++; if (wd_q.size() !== 16) begin n_fail++; $display("FAIL hold_write_count: got %0d expected 16", wd_q.size()); end
  endtask

  task automatic test_reset_midcopy();
    int n; int errs; logic found; logic [9:0] a0; logic [5:0] s0; logic [6:0] rd0;
    press(1'b1, 1'b0); wait_load(n, a0, s0, rd0);
    press(1'b1, 1'b0); wait_load(n, a0, s0, rd0);
    press(1'b1, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge CLK_50);
      if (ram_wren && ram_wraddress == 7'd5) found = 1'b1;
      else step();
    end
    n_tests++; if (found !== 1'b1 || ram_data !== 32'd53) begin
      n_fail++; $display("FAIL midcopy_write5: got found=%b data=%0d expected found=1 data=53", found, ram_data);
    end
    reset = 1'b1;
    step();
    clear_q();
    reset = 1'b0;
    wait_load(n, a0, s0, rd0);
    n_tests++; if (s0 !== 6'd0 || a0 !== 10'd0) begin n_fail++; $display("FAIL midcopy_restart: got seq=%0d addr=%0d expected seq=0 addr=0", s0, a0); end
    n_tests++; if (n !== 18) begin n_fail++; $display("FAIL midcopy_load_cycles: got %0d expected 18", n); end
    n_tests++; if (wd_q.size() !== 16) begin n_fail++; $display("FAIL midcopy_write_count: got %0d expected 16", wd_q.size()); end
    errs = 0;
    foreach (wd_q[k]) if (wa_q[k] !== 7'(k) || wd_q[k] !== 32'(k)) errs++;
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL midcopy_write_data: got %0d bad writes expected 0", errs); end
  endtask

  task automatic test_tick_vs_button();
    int n; logic [9:0] a0; logic [5:0] s0; logic [6:0] rd0;
    step();
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    @(negedge CLK_50);
    n_tests++; if (ram_rdaddress !== 7'd1) begin n_fail++; $display("FAIL tvb_pre_tick: got %0d expected 1", ram_rdaddress); end
    step();
    step_tick = 1'b1;
    pb_seq_dn = 1'b1;
    step();
    step_tick = 1'b0;
    pb_seq_dn = 1'b0;
    wait_load(n, a0, s0, rd0);
    n_tests++; if (s0 !== 6'd7 || rd0 !== 7'd0) begin n_fail++; $display("FAIL tvb_button_wins: got seq=%0d rd=%0d expected seq=7 rd=0", s0, rd0); end
  endtask

  task automatic test_load_ignores_inputs();
    int extra;
    extra = 0;
    clear_q();
    press(1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step_tick = 1'b1;
      pb_seq_dn = (c == 2);
      step();
    end
    step_tick = 1'b0;
    pb_seq_dn = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK_50);
      if (!loading) break;
      step();
    end
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge CLK_50);
      if (loading) extra++;
    end
    n_tests++; if (seq_num !== 6'd0) begin n_fail++; $display("FAIL ign_seq_num: got %0d expected 0", seq_num); end
    n_tests++; if (ram_rdaddress !== 7'd0) begin n_fail++; $display("FAIL ign_rdaddress: got %0d expected 0", ram_rdaddress); end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL ign_retrigger: got %0d loading cycles expected 0", extra); end
    n_tests++; if (wd_q.size() !== 16) begin n_fail++; $display("FAIL ign_write_count: got %0d expected 16", wd_q.size()); end
  endtask

  initial begin
    test_reset();
    test_initial_load();
    test_play_ticks();
    test_seq_up();
    test_seq_dn_wrap();
    test_both_buttons();
    test_hold_button();
    test_reset_midcopy();
    test_tick_vs_button();
    test_load_ignores_inputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
